// File: rtl/serial_lane_arbiter_pkg.sv
// Shared definitions for the serial lane arbiter.
//   state_t    : deserializer FSM states
//   DEF_*      : default parameter values for lane count, frame size, timeout
//   idx_width  : width of a lane index, never smaller than one bit
package serial_lane_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        ABORT
    } state_t;

    localparam int DEF_NUM_LANES  = 4;
    localparam int DEF_FRAME_BITS = 8;
    localparam int DEF_TIMEOUT    = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_lane_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per lane
//   ptr   : highest-priority lane index for this decision
//   grant : one-hot winner (all zero when nothing requests)
//   idx   : index of the winner (zero when nothing requests)
module rr_arbiter
    import serial_lane_arbiter_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES
) (
    input  logic [NUM_LANES-1:0]            req,
    input  logic [idx_width(NUM_LANES)-1:0] ptr,
    output logic [NUM_LANES-1:0]            grant,
    output logic [idx_width(NUM_LANES)-1:0] idx
);

    localparam int IW = idx_width(NUM_LANES);

    logic          found;
    logic [IW:0]   cand;   // one spare bit so ptr + offset cannot overflow

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Walk lanes in wrapped order starting at ptr; first requester wins.
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_LANES)) begin
                cand = cand - (IW+1)'(NUM_LANES);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                grant[cand[IW-1:0]]  = 1'b1;
                idx                  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/serial_lane_arbiter.sv
// Arbitrates several serial requesters onto one deserializer.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   lane_req      : per-lane request, held while a frame is pending
//   lane_din      : per-lane serial data bit
//   lane_valid    : per-lane bit qualifier
//   lane_grant    : registered one-hot grant to the lane being deserialized
//   dout_parallel : last completed frame, first received bit in the MSB
//   dout_lane     : lane of the last completed or aborted frame
//   dout_valid    : one-cycle pulse for a completed frame
//   err_timeout   : one-cycle pulse for an aborted frame (timeout or request drop)
module serial_lane_arbiter
    import serial_lane_arbiter_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LANES-1:0]             lane_req,
    input  logic [NUM_LANES-1:0]             lane_din,
    input  logic [NUM_LANES-1:0]             lane_valid,
    output logic [NUM_LANES-1:0]             lane_grant,
    output logic [FRAME_BITS-1:0]            dout_parallel,
    output logic [idx_width(NUM_LANES)-1:0]  dout_lane,
    output logic                             dout_valid,
    output logic                             err_timeout
);

    localparam int LW = idx_width(NUM_LANES);
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                state;
    logic [LW-1:0]         sel;
    logic [LW-1:0]         rr_ptr;
    logic [LW-1:0]         next_ptr;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         idle_tmr;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [NUM_LANES-1:0]  arb_grant;
    logic [LW-1:0]         arb_idx;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_rr_arbiter (
        .req   (lane_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Priority moves to the lane after the one just served, wrapping to 0.
    assign next_ptr = (sel == LW'(NUM_LANES - 1)) ? '0 : sel + LW'(1);

    // NOTE: all state, including the shift register, is cleared by reset so a
    // frame cut off by reset leaves nothing behind that could leak out later.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sel           <= '0;
            rr_ptr        <= '0;
            bit_cnt       <= '0;
            idle_tmr      <= '0;
            shift_reg     <= '0;
            lane_grant    <= '0;
            dout_parallel <= '0;
            dout_lane     <= '0;
            dout_valid    <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            dout_valid  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|lane_req) begin
                        sel        <= arb_idx;
                        lane_grant <= arb_grant;
                        bit_cnt    <= '0;
                        idle_tmr   <= '0;
                        shift_reg  <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Request drop is checked first so a bit arriving with the
                    // falling request is thrown away with the rest of the frame.
                    if (!lane_req[sel]) begin
                        lane_grant <= '0;
                        state      <= ABORT;
                    end else if (lane_valid[sel]) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], lane_din[sel]};
                        bit_cnt   <= bit_cnt + CW'(1);
                        idle_tmr  <= '0;
                        if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                            lane_grant <= '0;
                            state      <= DONE;
                        end
                    end else if (idle_tmr == TW'(TIMEOUT - 1)) begin
                        idle_tmr   <= TW'(TIMEOUT);
                        lane_grant <= '0;
                        state      <= ABORT;
                    end else begin
                        idle_tmr <= idle_tmr + TW'(1);
                    end
                end
                DONE: begin
                    dout_parallel <= shift_reg;
                    dout_lane     <= sel;
                    dout_valid    <= 1'b1;
                    rr_ptr        <= next_ptr;
                    state         <= IDLE;
                end
                ABORT: begin
                    err_timeout <= 1'b1;
                    dout_lane   <= sel;
                    rr_ptr      <= next_ptr;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_lane_arbiter.sv
// Directed bench for serial_lane_arbiter: a table of whole-frame vectors
// followed by hand-written timeout, request-drop and reset sequences.
module tb_serial_lane_arbiter;

    localparam int NL = 4;
    localparam int FB = 8;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic [NL-1:0] lane_req;
    logic [NL-1:0] lane_din;
    logic [NL-1:0] lane_valid;
    logic [NL-1:0] lane_grant;
    logic [FB-1:0] dout_parallel;
    logic [1:0]    dout_lane;
    logic          dout_valid;
    logic          err_timeout;

    serial_lane_arbiter #(
        .NUM_LANES  (NL),
        .FRAME_BITS (FB),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lane_req      (lane_req),
        .lane_din      (lane_din),
        .lane_valid    (lane_valid),
        .lane_grant    (lane_grant),
        .dout_parallel (dout_parallel),
        .dout_lane     (dout_lane),
        .dout_valid    (dout_valid),
        .err_timeout   (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        lane_valid = '0;
        lane_din   = '0;
    endtask

    task automatic drive_bit(input int lane, input logic b, input logic [NL-1:0] noise);
        lane_valid       = noise;
        lane_din         = noise & {NL{~b}};
        lane_valid[lane] = 1'b1;
        lane_din[lane]   = b;
    endtask

    // Waits (bounded) at negedges for any grant, then checks it is the expected lane.
    task automatic wait_grant(input int lane);
        logic [NL-1:0] exp_g;
        exp_g = '0;
        exp_g[lane] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (|lane_grant) break;
        end
        check("grant", 32'(lane_grant), 32'(exp_g));
        check("no_pulse_at_grant", {30'd0, dout_valid, err_timeout}, 32'd0);
    endtask

    // Called at the negedge where the grant is first visible.
    task automatic run_frame(input int lane, input logic [FB-1:0] data, input logic [NL-1:0] noise);
        for (int b = 0; b < FB; b++) begin
            drive_bit(lane, data[FB-1-b], noise);
            @(negedge clk);
        end
        idle_inputs();
        check("grant_drop_done", 32'(lane_grant), 32'd0);
        check("valid_not_early", 32'(dout_valid), 32'd0);
        @(negedge clk);
        check("dout_valid", 32'(dout_valid), 32'd1);
        check("dout_parallel", 32'(dout_parallel), 32'(data));
        check("dout_lane", 32'(dout_lane), 32'(lane));
        check("no_err_on_done", 32'(err_timeout), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        lane_req = '0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NL-1:0] req;
        logic [NL-1:0] noise;
        int            lane;
        logic [FB-1:0] data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Round-robin over all four lanes from reset, then pointer-sensitive cases.
        vecs[0]  = '{4'hF, 4'h0, 0, 8'h11};
        vecs[1]  = '{4'hF, 4'h0, 1, 8'h22};
        vecs[2]  = '{4'hF, 4'h0, 2, 8'h44};
        vecs[3]  = '{4'hF, 4'h0, 3, 8'h88};
        vecs[4]  = '{4'hF, 4'h0, 0, 8'h0F};
        vecs[5]  = '{4'h4, 4'h0, 2, 8'hA5};
        vecs[6]  = '{4'h1, 4'h8, 0, 8'h3C};
        vecs[7]  = '{4'h9, 4'h0, 3, 8'hFF};
        vecs[8]  = '{4'h9, 4'h0, 0, 8'h00};
        vecs[9]  = '{4'hA, 4'h0, 1, 8'h81};
        vecs[10] = '{4'hA, 4'h0, 3, 8'h7E};

        rst      = 1'b1;
        lane_req = '0;
        idle_inputs();
        @(negedge clk);
        check("rst_grant", 32'(lane_grant), 32'd0);
        check("rst_dout", 32'(dout_parallel), 32'd0);
        check("rst_lane", 32'(dout_lane), 32'd0);
        check("rst_pulses", {30'd0, dout_valid, err_timeout}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 11; v++) begin
            lane_req = vecs[v].req;
            wait_grant(vecs[v].lane);
            run_frame(vecs[v].lane, vecs[v].data, vecs[v].noise);
        end

        // Reset in the middle of a lane 1 frame: everything clears at once.
        lane_req = 4'h2;
        wait_grant(1);
        for (int b = 0; b < 4; b++) begin
            drive_bit(1, 1'b1, 4'h0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_grant", 32'(lane_grant), 32'd0);
        check("midrst_dout", 32'(dout_parallel), 32'd0);
        check("midrst_lane", 32'(dout_lane), 32'd0);
        lane_req = 4'h6;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_quiet", {28'd0, lane_grant[1:0], dout_valid, err_timeout}, 32'd0);
        end
        rst = 1'b0;
        wait_grant(1);
        run_frame(1, 8'h5A, 4'h0);

        // Timeout on lane 1 after 3 bits; lane 2 also waiting.
        do_reset();
        lane_req = 4'h6;
        wait_grant(1);
        for (int b = 0; b < 3; b++) begin
            drive_bit(1, 1'b1, 4'h0);
            @(negedge clk);
        end
        idle_inputs();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k == TO - 1) check("to_grant_held", 32'(lane_grant), 32'h2);
            if (k == TO)     check("to_grant_drop", 32'(lane_grant), 32'd0);
        end
        @(negedge clk);
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_lane", 32'(dout_lane), 32'd1);
        check("to_no_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        check("to_next_grant", 32'(lane_grant), 32'h4);
        check("to_err_pulse", 32'(err_timeout), 32'd0);

        // Lane 0 drops its request after 5 bits, with a valid bit on the drop cycle.
        do_reset();
        lane_req = 4'h1;
        wait_grant(0);
        for (int b = 0; b < 5; b++) begin
            drive_bit(0, 1'b0, 4'h0);
            @(negedge clk);
        end
        check("drop_grant_held", 32'(lane_grant), 32'h1);
        lane_req = 4'h0;
        drive_bit(0, 1'b1, 4'h0);
        @(negedge clk);
        idle_inputs();
        check("drop_grant_off", 32'(lane_grant), 32'd0);
        @(negedge clk);
        check("drop_err", 32'(err_timeout), 32'd1);
        check("drop_lane", 32'(dout_lane), 32'd0);
        check("drop_no_valid", 32'(dout_valid), 32'd0);

        // Lane 2: 8th bit arrives on the same cycle its request falls; abort wins.
        do_reset();
        lane_req = 4'h4;
        wait_grant(2);
        for (int b = 0; b < FB - 1; b++) begin
            drive_bit(2, 1'b1, 4'h0);
            @(negedge clk);
        end
        drive_bit(2, 1'b1, 4'h0);
        lane_req = 4'h0;
        @(negedge clk);
        idle_inputs();
        check("last_drop_grant", 32'(lane_grant), 32'd0);
        @(negedge clk);
        check("last_drop_err", 32'(err_timeout), 32'd1);
        check("last_drop_valid", 32'(dout_valid), 32'd0);
        check("last_drop_lane", 32'(dout_lane), 32'd2);
        check("last_drop_dout", 32'(dout_parallel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
